// File: rtl/uart_cmd_framer.sv
// ---------------------------------------------------------------------------
// uart_cmd_framer
//
// Framed command parser sitting between uart_rx and the SoC control
// registers. Raw received bytes are assembled into 4-byte frames
//   SYNC, OP, ARG, CHK   with CHK = OP ^ ARG
// A good frame produces a one-cycle cmd_valid strobe with cmd_op/cmd_arg and
// queues an ACK byte for uart_tx. A bad checksum (or a mid-frame timeout when
// enabled) queues a NAK and bumps a saturating error counter. Because a
// command needs a full matching frame, line noise cannot toggle clock or
// reset controls.
//
// Optional feature macro: UART_CMD_TIMEOUT_EN
//   defined   : an inter-byte idle counter aborts a stalled partial frame
//               after TIMEOUT_CYCLES cycles (NAK + error count).
//   undefined : no counter; a partial frame waits until rx_break or reset.
//
// Handshakes: rx_valid is a one-cycle strobe with no back-pressure (the
// parser always accepts). Toward uart_tx, tx_en fires for exactly one cycle
// when a response is pending and tx_busy is low; tx_busy acts as not-ready.
//
// Ports
//   clk27          in   system clock, 27 MHz
//   reset          in   synchronous, active-high
//   rx_valid       in   received-byte strobe
//   rx_data  [7:0] in   received byte
//   rx_break       in   BREAK detected; aborts the current frame
//   tx_busy        in   uart_tx busy transmitting
//   tx_en          out  one-cycle load strobe for uart_tx
//   tx_data  [7:0] out  response byte (held after tx_en)
//   cmd_valid      out  one-cycle strobe for a validated command
//   cmd_op   [7:0] out  opcode, held until the next cmd_valid
//   cmd_arg  [7:0] out  argument, held until the next cmd_valid
//   frame_busy     out  high while a frame is being assembled
//   frame_err_cnt  out  saturating count of bad frames
//   resp_overrun   out  sticky: a pending response was overwritten
//   fsm_state[1:0] out  debug view of the parser state
// ---------------------------------------------------------------------------
module uart_cmd_framer #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [7:0]  ACK_BYTE       = 8'h06,
  parameter logic [7:0]  NAK_BYTE       = 8'h15,
  parameter int unsigned TIMEOUT_CYCLES = 270000
) (
  input  logic       clk27,
  input  logic       reset,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_break,
  input  logic       tx_busy,
  output logic       tx_en,
  output logic [7:0] tx_data,
  output logic       cmd_valid,
  output logic [7:0] cmd_op,
  output logic [7:0] cmd_arg,
  output logic       frame_busy,
  output logic [7:0] frame_err_cnt,
  output logic       resp_overrun,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    S_SYNC = 2'd0,
    S_OP   = 2'd1,
    S_ARG  = 2'd2,
    S_CHK  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] op_q, arg_q;
  logic       resp_push;
  logic [7:0] resp_byte;
  logic       err_inc;
  logic       cmd_fire;
  logic       timeout_hit;
  logic       pend_q;

  // -------------------------------------------------------------------------
  // Optional inter-byte timeout
  // -------------------------------------------------------------------------
`ifdef UART_CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] to_cnt_q;

  // A byte or a break in the same cycle always wins over the timeout.
  assign timeout_hit = (state_q != S_SYNC) && !rx_break && !rx_valid &&
                       (to_cnt_q == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk27) begin
    if (reset || rx_valid || rx_break || timeout_hit || (state_q == S_SYNC)) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + TW'(1);
    end
  end
`else
  // No counter in this build; the parameter only sets the interface.
  assign timeout_hit = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  // -------------------------------------------------------------------------
  // Parser FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk27) begin
    if (reset) begin
      state_q <= S_SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    resp_push = 1'b0;
    resp_byte = ACK_BYTE;
    err_inc   = 1'b0;
    cmd_fire  = 1'b0;
    if (rx_break) begin
      // Abort silently: no response, no error count.
      state_d = S_SYNC;
    end else if (rx_valid) begin
      unique case (state_q)
        S_SYNC: if (rx_data == SYNC_BYTE) state_d = S_OP;
        // A SYNC_BYTE value here is taken as an opcode, never a resync.
        S_OP:   state_d = S_ARG;
        S_ARG:  state_d = S_CHK;
        S_CHK: begin
          state_d   = S_SYNC;
          resp_push = 1'b1;
          if (rx_data == (op_q ^ arg_q)) begin
            cmd_fire  = 1'b1;
            resp_byte = ACK_BYTE;
          end else begin
            err_inc   = 1'b1;
            resp_byte = NAK_BYTE;
          end
        end
        default: state_d = S_SYNC;
      endcase
    end else if (timeout_hit) begin
      state_d   = S_SYNC;
      resp_push = 1'b1;
      resp_byte = NAK_BYTE;
      err_inc   = 1'b1;
    end
  end

  assign frame_busy = (state_q != S_SYNC);
  assign fsm_state  = state_q;

  // Operand capture for the frame in progress.
  always_ff @(posedge clk27) begin
    if (reset) begin
      op_q  <= '0;
      arg_q <= '0;
    end else if (rx_valid && !rx_break) begin
      if (state_q == S_OP)  op_q  <= rx_data;
      if (state_q == S_ARG) arg_q <= rx_data;
    end
  end

  // -------------------------------------------------------------------------
  // Command outputs and error counter
  // -------------------------------------------------------------------------
  always_ff @(posedge clk27) begin
    if (reset) begin
      cmd_valid     <= 1'b0;
      cmd_op        <= '0;
      cmd_arg       <= '0;
      frame_err_cnt <= '0;
    end else begin
      cmd_valid <= cmd_fire;
      if (cmd_fire) begin
        cmd_op  <= op_q;
        cmd_arg <= arg_q;
      end
      if (err_inc && (frame_err_cnt != 8'hFF)) begin
        frame_err_cnt <= frame_err_cnt + 8'd1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // One-entry response slot. tx_data doubles as the stored byte, so it stays
  // valid through the tx_en cycle and is held afterwards.
  // -------------------------------------------------------------------------
  assign tx_en = pend_q & ~tx_busy;

  always_ff @(posedge clk27) begin
    if (reset) begin
      pend_q       <= 1'b0;
      tx_data      <= '0;
      resp_overrun <= 1'b0;
    end else if (resp_push) begin
      pend_q  <= 1'b1;
      tx_data <= resp_byte;
      // Replacing a byte that is being sent this very cycle is not a loss.
      if (pend_q && !tx_en) resp_overrun <= 1'b1;
    end else if (tx_en) begin
      pend_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_cmd_framer.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_framer
//
// Bench for uart_cmd_framer: reset checks, a table of byte sequences with
// expected command/response/error results, hand-written sequences for
// overrun, break, timeout, reset mid-frame and error saturation, and a
// randomized phase scored against a byte-level frame model.
// ---------------------------------------------------------------------------
module tb_uart_cmd_framer;

  localparam int TO = 50;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic       clk27 = 1'b0;
  logic       reset;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_break;
  logic       tx_busy;
  logic       tx_en;
  logic [7:0] tx_data;
  logic       cmd_valid;
  logic [7:0] cmd_op;
  logic [7:0] cmd_arg;
  logic       frame_busy;
  logic [7:0] frame_err_cnt;
  logic       resp_overrun;
  logic [1:0] fsm_state;

  always #5 clk27 = ~clk27;

  uart_cmd_framer #(
    .SYNC_BYTE     (8'hA5),
    .ACK_BYTE      (8'h06),
    .NAK_BYTE      (8'h15),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk27        (clk27),
    .reset        (reset),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_break     (rx_break),
    .tx_busy      (tx_busy),
    .tx_en        (tx_en),
    .tx_data      (tx_data),
    .cmd_valid    (cmd_valid),
    .cmd_op       (cmd_op),
    .cmd_arg      (cmd_arg),
    .frame_busy   (frame_busy),
    .frame_err_cnt(frame_err_cnt),
    .resp_overrun (resp_overrun),
    .fsm_state    (fsm_state)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model: byte-level frame assembly with queues
  // -------------------------------------------------------------------------
  logic [15:0] exp_cmd_q[$];
  logic [7:0]  exp_tx_q[$];
  logic [7:0]  frame_q[$];
  int          model_err;
  bit          sb_on = 1'b0;

  task automatic model_byte(input logic [7:0] b);
    if (frame_q.size() == 0 && b != 8'hA5) return;
    frame_q.push_back(b);
    if (frame_q.size() == 4) begin
      if ((frame_q[1] ^ frame_q[2]) == frame_q[3]) begin
        exp_cmd_q.push_back({frame_q[1], frame_q[2]});
        exp_tx_q.push_back(8'h06);
      end else begin
        exp_tx_q.push_back(8'h15);
        if (model_err < 255) model_err++;
      end
      frame_q.delete();
    end
  endtask

  // -------------------------------------------------------------------------
  // Monitor / scoreboard (samples on the falling edge)
  // -------------------------------------------------------------------------
  int         tx_cnt  = 0;
  int         cmd_cnt = 0;
  logic [7:0] last_tx = 8'h00;

  always @(negedge clk27) begin
    if (tx_en === 1'b1) begin
      tx_cnt++;
      last_tx = tx_data;
      if (sb_on) begin
        if (exp_tx_q.size() == 0) check("sb_tx_unexpected", tx_en, 0);
        else check("sb_tx_data", tx_data, exp_tx_q.pop_front());
      end
    end
    if (cmd_valid === 1'b1) begin
      cmd_cnt++;
      if (sb_on) begin
        if (exp_cmd_q.size() == 0) check("sb_cmd_unexpected", cmd_valid, 0);
        else check("sb_cmd", {cmd_op, cmd_arg}, exp_cmd_q.pop_front());
      end
    end
  end

  // -------------------------------------------------------------------------
  // Driver tasks (inputs change 1 time unit after the rising edge)
  // -------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk27);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    if (sb_on) model_byte(b);
    tick(1);
    rx_valid = 1'b0;
    tick(gap);
  endtask

  task automatic send_break(input logic with_byte, input logic [7:0] b);
    rx_break = 1'b1;
    rx_valid = with_byte;
    rx_data  = b;
    if (sb_on) frame_q.delete();
    tick(1);
    rx_break = 1'b0;
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    @(negedge clk27);
    check({tag, "_tx_en"},      tx_en, 0);
    check({tag, "_tx_data"},    tx_data, 0);
    check({tag, "_cmd_valid"},  cmd_valid, 0);
    check({tag, "_cmd_op"},     cmd_op, 0);
    check({tag, "_cmd_arg"},    cmd_arg, 0);
    check({tag, "_frame_busy"}, frame_busy, 0);
    check({tag, "_err_cnt"},    frame_err_cnt, 0);
    check({tag, "_overrun"},    resp_overrun, 0);
    check({tag, "_fsm_state"},  fsm_state, 0);
    @(posedge clk27);
    #1;
  endtask

  // -------------------------------------------------------------------------
  // Stimulus table
  // -------------------------------------------------------------------------
  typedef struct {
    logic [55:0] bytes;   // byte i at bits [8*(n-1-i) +: 8]
    int          n;
    logic        exp_cmd;
    logic [7:0]  exp_op;
    logic [7:0]  exp_arg;
    logic [7:0]  exp_tx;
    logic [7:0]  exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : main
    int tc, cc;
    int e0;
    logic [7:0] b, op, arg, chk;

    vecs[0] = '{56'hA5023230,         4, 1'b1, 8'h02, 8'h32, 8'h06, 8'd0};
    vecs[1] = '{56'hA5050000,         4, 1'b0, 8'h02, 8'h32, 8'h15, 8'd1};
    vecs[2] = '{56'h00FF13A5010001,   7, 1'b1, 8'h01, 8'h00, 8'h06, 8'd1};
    vecs[3] = '{56'hA5A50FAA,         4, 1'b1, 8'hA5, 8'h0F, 8'h06, 8'd1};
    vecs[4] = '{56'hA5102031,         4, 1'b0, 8'hA5, 8'h0F, 8'h15, 8'd2};
    vecs[5] = '{56'hA5FFFF00,         4, 1'b1, 8'hFF, 8'hFF, 8'h06, 8'd2};

    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rx_break = 1'b0;
    tx_busy  = 1'b0;
    tick(3);
    reset = 1'b0;
    check_all_zero("reset");

    // ---- table-driven frames -------------------------------------------
    for (int v = 0; v < 6; v++) begin
      tc = tx_cnt;
      cc = cmd_cnt;
      for (int i = 0; i < vecs[v].n - 1; i++) begin
        send_byte(vecs[v].bytes[8*(vecs[v].n-1-i) +: 8], 1);
      end
      // Last byte: command and response appear the very next cycle.
      rx_valid = 1'b1;
      rx_data  = vecs[v].bytes[7:0];
      tick(1);
      rx_valid = 1'b0;
      @(negedge clk27);
      check($sformatf("v%0d_cmd_valid_lat", v), cmd_valid, vecs[v].exp_cmd);
      check($sformatf("v%0d_tx_en_lat", v),     tx_en, 1);
      check($sformatf("v%0d_tx_data", v),       tx_data, vecs[v].exp_tx);
      tick(3);
      check($sformatf("v%0d_cmd_op", v),     cmd_op, vecs[v].exp_op);
      check($sformatf("v%0d_cmd_arg", v),    cmd_arg, vecs[v].exp_arg);
      check($sformatf("v%0d_err_cnt", v),    frame_err_cnt, vecs[v].exp_err);
      check($sformatf("v%0d_frame_busy", v), frame_busy, 0);
      check($sformatf("v%0d_tx_count", v),   tx_cnt - tc, 1);
      check($sformatf("v%0d_cmd_count", v),  cmd_cnt - cc, vecs[v].exp_cmd);
    end
    check("no_overrun_yet", resp_overrun, 0);

    // ---- overrun: tx_busy high across two good frames -------------------
    tc = tx_cnt;
    tx_busy = 1'b1;
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0);
    send_byte(8'hA5, 0); send_byte(8'h04, 0); send_byte(8'h05, 0); send_byte(8'h01, 0);
    tick(92);
    check("ovr_no_tx_while_busy", tx_cnt - tc, 0);
    check("ovr_flag", resp_overrun, 1);
    check("ovr_cmd_op", cmd_op, 8'h04);
    check("ovr_cmd_arg", cmd_arg, 8'h05);
    tx_busy = 1'b0;
    tick(5);
    check("ovr_single_tx", tx_cnt - tc, 1);
    check("ovr_tx_data", last_tx, 8'h06);

    // ---- break mid-frame --------------------------------------------------
    tc = tx_cnt;
    cc = cmd_cnt;
    e0 = frame_err_cnt;
    send_byte(8'hA5, 0);
    send_byte(8'h03, 0);
    check("brk_busy_before", frame_busy, 1);
    send_break(1'b0, 8'h00);
    check("brk_busy_after", frame_busy, 0);
    tick(3);
    check("brk_no_tx", tx_cnt - tc, 0);
    send_byte(8'hA5, 0); send_byte(8'h03, 0); send_byte(8'h00, 0); send_byte(8'h03, 0);
    tick(2);
    check("brk_then_cmd_count", cmd_cnt - cc, 1);
    check("brk_then_cmd_op", cmd_op, 8'h03);
    check("brk_then_cmd_arg", cmd_arg, 8'h00);

    // Break and a byte in the same cycle: the break wins, byte is dropped.
    cc = cmd_cnt;
    send_byte(8'hA5, 0);
    send_break(1'b1, 8'h00);
    check("brk_prio_busy", frame_busy, 0);
    send_byte(8'h03, 0); send_byte(8'h00, 0); send_byte(8'h03, 0);
    tick(2);
    check("brk_prio_no_cmd", cmd_cnt - cc, 0);
    check("brk_prio_err", frame_err_cnt, e0);

    // ---- mid-frame idle -------------------------------------------------
    tc = tx_cnt;
    e0 = frame_err_cnt;
    send_byte(8'hA5, 0);
`ifdef UART_CMD_TIMEOUT_EN
    tick(TO - 5);
    check("to_not_early", frame_busy, 1);
    for (int k = 0; k < 100 && tx_cnt == tc; k++) tick(1);
    check("to_tx_count", tx_cnt - tc, 1);
    check("to_tx_nak", last_tx, 8'h15);
    check("to_err_cnt", frame_err_cnt, e0 + 1);
    check("to_back_in_sync", frame_busy, 0);
`else
    tick(1000);
    check("nto_still_busy", frame_busy, 1);
    check("nto_no_tx", tx_cnt - tc, 0);
    check("nto_err_cnt", frame_err_cnt, e0);
    send_break(1'b0, 8'h00);
`endif

    // ---- reset mid-frame with a response pending -----------------------
    tx_busy = 1'b1;
    send_byte(8'hA5, 0); send_byte(8'h07, 0); send_byte(8'h01, 0); send_byte(8'h06, 0);
    send_byte(8'hA5, 0); send_byte(8'h01, 0);
    tc = tx_cnt;
    do_reset();
    check_all_zero("rst_mid");
    tx_busy = 1'b0;
    tick(10);
    check("rst_mid_no_tx", tx_cnt - tc, 0);
    send_byte(8'h02, 1);
    check("rst_mid_frame_dropped", frame_busy, 0);

    // ---- error counter saturation -----------------------------------------
    do_reset();
    for (int i = 0; i < 300; i++) begin
      send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h01, 0);
      if (i == 253) check("sat_fe", frame_err_cnt, 8'hFE);
    end
    check("sat_ff", frame_err_cnt, 8'hFF);

    // ---- randomized frames vs. model --------------------------------------
    do_reset();
    exp_cmd_q.delete();
    exp_tx_q.delete();
    frame_q.delete();
    model_err = 0;
    sb_on = 1'b1;
    for (int ev = 0; ev < 300; ev++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 55) begin
        op  = 8'($urandom_range(0, 255));
        arg = 8'($urandom_range(0, 255));
        chk = op ^ arg;
        if ($urandom_range(0, 3) == 0) chk = chk ^ (8'h01 << $urandom_range(0, 7));
        send_byte(8'hA5, $urandom_range(0, 3));
        send_byte(op,    $urandom_range(0, 3));
        send_byte(arg,   $urandom_range(0, 3));
        send_byte(chk,   $urandom_range(0, 3));
      end else if (r < 75) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h5A;
        send_byte(b, $urandom_range(0, 3));
      end else begin
        send_byte(8'hA5, $urandom_range(0, 3));
        for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
          send_byte(8'($urandom_range(0, 255)), $urandom_range(0, 3));
        end
        send_break(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      end
    end
    tick(5);
    check("rnd_tx_drained", exp_tx_q.size(), 0);
    check("rnd_cmd_drained", exp_cmd_q.size(), 0);
    check("rnd_err_cnt", frame_err_cnt, model_err);
    check("rnd_no_overrun", resp_overrun, 0);
    sb_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
